serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Serialises one DATA_W-bit parallel word onto a single line: start bit, data LSB first,
//  optional parity bit, stop bit. Each bit is held for CLKS_PER_BIT clocks.
//  This is the transmit end of the team's serial link.
//  It sits between a parallel producer (valid/ready handshake) and the board's serial pin.
// PARAMETERS
//  DATA_W        9  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clocks per serial bit (>=1); the bench uses 4
// PORTS
//  clk       in   1       single clock; all logic on posedge
//  rst       in   1       asynchronous, active-high reset
//  tx_data   in   DATA_W  word to send; sampled only on handshake
//  tx_valid  in   1       producer has a word
//  tx_ready  out  1       block accepts a word this cycle (high only in IDLE)
//  tx        out  1       serial line, idle high, registered
//  busy      out  1       high from the cycle after the handshake until the return to IDLE
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=IDLE, tx=1, tx_ready=1, busy=0.
//   Bit and clock counters and the shift register clear to 0. Any frame in flight is dropped.
//  Handshake: accept when tx_valid&&tx_ready at a posedge.
//   tx_data is latched into a shift register on that edge. Later tx_data changes are ignored.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1; on handshake go to START.
//   START: tx=0 for CLKS_PER_BIT clocks.
//   DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT clocks; shift right on bit end.
//   PARITY: even parity (XOR of all DATA_W bits), held CLKS_PER_BIT clocks.
//   STOP: tx=1 for CLKS_PER_BIT clocks, then IDLE.
//  Latency: tx falls on the first posedge after the handshake edge, i.e. the start bit
//   begins 1 clock after acceptance.
//  Clock counter: width $clog2(CLKS_PER_BIT) (min 1); wraps 0..CLKS_PER_BIT-1.
//   A bit ends when count==CLKS_PER_BIT-1. With CLKS_PER_BIT=1, every clock is a bit.
//  Bit counter: width $clog2(DATA_W) (min 1); counts 0..DATA_W-1 in DATA, clears leaving DATA.
//  Frame length: (DATA_W+2)*CLKS_PER_BIT clocks, +CLKS_PER_BIT when parity is compiled in.
//  Back-to-back: IDLE always lasts >=1 clock, so tx_ready is high exactly 1 cycle between frames
//   when tx_valid is held. Frame-to-frame period = frame length + 1.
//  tx_valid high outside IDLE: no effect; the word stays pending.
//   tx_valid may drop without a handshake.
//  busy is the inverse of (state==IDLE).
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined: the PARITY state is present and each frame carries an even
//   parity bit.
//  Not defined: PARITY state and parity logic are absent; DATA goes straight to STOP.
// STRUCTURE
//  Package serial_pkg holds:
//   - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
//   - localparams for line levels: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
//  One sub-module: serial_bit_timer.
//   - Owns the clock counter; inputs clk, rst, run.
//   - Output bit_end: a 1-cycle pulse every CLKS_PER_BIT clocks while run is high.
//   - The counter clears while run is low.
//  The FSM, shift register and bit counter are in serial_tx.
// TESTING (DATA_W=9, CLKS_PER_BIT=4)
//  Reset idle: assert rst for 3 clocks -> tx=1, tx_ready=1, busy=0. Hold tx_valid=0 ->
//   tx stays 1.
//  Single frame: tx_data=9'h1A5, 1-cycle valid.
//   tx = 0 x4, then 1,0,1,0,0,1,0,1,1 each x4, then 1 x4.
//   44 clocks total; tx_ready returns high at clock 45.
//  Parity (SERIAL_TX_PARITY_EN): 9'h1A5 -> parity bit 1 after bit8 (x4), 48 clocks total.
//   9'h003 -> parity bit 0.
//  Back-to-back: hold tx_valid with 9'h000 then 9'h1FF.
//   Exactly 1 idle clock (tx=1, tx_ready=1) between the frames; second start edge at clock 46.
//  Ignored input: change tx_data to 9'h0FF during the DATA state of a 9'h100 frame ->
//   serial bits stay 0,0,0,0,0,0,0,0,1.
//  Reset mid-frame: assert rst during DATA bit 3 ->
//   tx=1 and tx_ready=1 before the next posedge.
//   After release a new 9'h055 frame transmits correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit path.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: pulses bit_end once every CLKS_PER_BIT clocks while run is high.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = run && (cnt == LAST);

    // Counter restarts at every bit boundary so consecutive bits line up without gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to include the parity bit in every frame.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 9,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    // Handshake: a word is taken on a posedge where tx_valid && tx_ready; tx_ready is
    // high only in IDLE, and tx_valid may be raised or dropped at any time without effect
    // until that edge.
    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              bit_end;
    logic              accept;
    logic              line_nx;
    logic              data_bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              par;
`endif

    assign tx_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = tx_valid && tx_ready;
    assign data_bit_end = (state == DATA) && bit_end;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (busy),
        .bit_end(bit_end)
    );

    // line_nx is the level for the current state; tx registers it, so the line trails
    // the state by one clock and the start bit begins one clock after acceptance.
    always_comb begin
        state_nx = state;
        line_nx  = LINE_IDLE;
        case (state)
            IDLE: begin
                if (accept) state_nx = START;
            end
            START: begin
                line_nx = START_BIT;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                line_nx = shreg[0];
                if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                line_nx = par;
                if (bit_end) state_nx = STOP;
            end
`endif
            STOP: begin
                line_nx = STOP_BIT;
                if (bit_end) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= LINE_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            tx    <= line_nx;
            if (accept) begin
                shreg <= tx_data;
            end else if (data_bit_end) begin
                shreg <= shreg >> 1;
            end
            if (data_bit_end) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity is taken from the word at acceptance, since the shift register is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=9, CLKS_PER_BIT=4); follows SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    localparam int DATA_W = 9;
    localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS  = DATA_W + 3;
`else
    localparam int NBITS  = DATA_W + 2;
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx;
    logic              busy;

    int errors = 0;
    int checks = 0;

    serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"}, 16'(tx), 16'h1);
        check({tag, " tx_ready"}, 16'(tx_ready), 16'h1);
        check({tag, " busy"}, 16'(busy), 16'h0);
    endtask

    // Called at a negedge; handshake on the next posedge, valid drops right after.
    task automatic handshake(input logic [DATA_W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("accept tx", 16'(tx), 16'h1);
        check("accept tx_ready", 16'(tx_ready), 16'h0);
        check("accept busy", 16'(busy), 16'h1);
    endtask

    // Checks every clock of the frame on tx; optionally rewrites tx_data mid-DATA.
    // Ends at the negedge of the cycle in which tx_ready returns high.
    task automatic check_bits(input logic [DATA_W-1:0] d, input logic poke,
                              input logic [DATA_W-1:0] poke_val);
        logic exp_bits [NBITS];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) exp_bits[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
        exp_bits[DATA_W+1] = ^d;
`endif
        exp_bits[NBITS-1] = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (poke && b == 4 && c == 0) tx_data = poke_val;
                check($sformatf("frame %0h bit%0d clk%0d tx", d, b, c), 16'(tx), 16'(exp_bits[b]));
                if (c == 0) check($sformatf("frame %0h bit%0d busy", d, b), 16'(busy), 16'h1);
            end
        end
        check($sformatf("frame %0h end tx_ready", d), 16'(tx_ready), 16'h1);
        check($sformatf("frame %0h end busy", d), 16'(busy), 16'h0);
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        // reset idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("in reset");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle no valid");
        end

        // single frame 9'h1A5
        handshake(9'h1A5);
        check_bits(9'h1A5, 1'b0, '0);
        @(negedge clk);
        check_idle("after 1A5");

`ifdef SERIAL_TX_PARITY_EN
        // zero parity frame
        handshake(9'h003);
        check_bits(9'h003, 1'b0, '0);
        @(negedge clk);
        check_idle("after 003");
`endif

        // back-to-back with tx_valid held
        tx_data  = 9'h000;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b accept tx_ready", 16'(tx_ready), 16'h0);
        check_bits(9'h000, 1'b1, 9'h1FF);
        check("b2b gap tx", 16'(tx), 16'h1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("b2b second accept tx", 16'(tx), 16'h1);
        check("b2b second accept tx_ready", 16'(tx_ready), 16'h0);
        check_bits(9'h1FF, 1'b0, '0);
        @(negedge clk);
        check_idle("after b2b");

        // tx_data changes during DATA are ignored
        handshake(9'h100);
        check_bits(9'h100, 1'b1, 9'h0FF);
        @(negedge clk);
        check_idle("after ignored input");

        // reset during data bit 3
        handshake(9'h1A5);
        repeat (17) @(negedge clk);
        check("mid data bit3 tx", 16'(tx), 16'h0);
        rst = 1'b1;
        #1;
        check_idle("async reset");
        repeat (2) @(negedge clk);
        check_idle("held reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post reset");
        handshake(9'h055);
        check_bits(9'h055, 1'b0, '0);
        @(negedge clk);
        check_idle("after 055");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
